// File: rtl/canny_pkg.sv
// Shared definitions for the Canny frame controller: FSM states, config addresses, width defaults.
package canny_pkg;

    localparam int unsigned DEF_W_THR = 10;
    localparam int unsigned DEF_W_CNT = 20;

    localparam logic [1:0] CFG_THR_LOW     = 2'd0;
    localparam logic [1:0] CFG_THR_HIGH    = 2'd1;
    localparam logic [1:0] CFG_BORDER_ROWS = 2'd2;
    localparam logic [1:0] CFG_BORDER_COLS = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StCommit
    } frame_state_e;

endpackage

// File: rtl/canny_pos_cnt.sv
// Row/column position tracking within the active frame and the border-suppression mask.
module canny_pos_cnt
    import canny_pkg::*;
#(
    parameter int unsigned W_POS = 11
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             clr,
    input  logic             active,
    input  logic             in_de,
    input  logic [W_POS-1:0] border_rows,
    input  logic [W_POS-1:0] border_cols,
    output logic             border_mask
);

    logic             de_q;
    logic [W_POS-1:0] row_q;
    logic [W_POS-1:0] col_q;
    logic [W_POS-1:0] row_cur;

    // The row number for the pixel on the bus: bumps on the first de cycle of a line,
    // so the mask already sees the new line on its first pixel.
    always_comb begin
        row_cur = row_q;
        if (active && in_de && !de_q && (row_q != '1)) begin
            row_cur = row_q + W_POS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            de_q  <= 1'b0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            de_q <= in_de;
            if (clr) begin
                row_q <= '0;
                col_q <= '0;
            end else begin
                if (active) begin
                    row_q <= row_cur;
                end
                if (!in_de) begin
                    col_q <= '0;
                end else if (col_q != '1) begin
                    col_q <= col_q + W_POS'(1);
                end
            end
        end
    end

    always_comb begin
        border_mask = active && in_de &&
                      (((border_rows != '0) && (row_cur <= border_rows)) ||
                       (col_q < border_cols));
    end

endmodule

// File: rtl/canny_frame_ctrl.sv
// Canny frame controller: shadowed threshold/border config committed at frame end, edge counting.
// Build macro CANNY_AUTO_THR_EN adds per-frame automatic adjustment of the high threshold.
module canny_frame_ctrl
    import canny_pkg::*;
#(
    parameter int unsigned W_THR           = DEF_W_THR,
    parameter int unsigned W_CNT           = DEF_W_CNT,
    parameter int unsigned W_POS           = 11,
    parameter int unsigned THR_LOW_RST     = 50,
    parameter int unsigned THR_HIGH_RST    = 100,
    parameter int unsigned BORDER_ROWS_RST = 5,
    parameter int unsigned BORDER_COLS_RST = 2
`ifdef CANNY_AUTO_THR_EN
    ,
    parameter int unsigned AUTO_STEP       = 4,
    parameter int unsigned AUTO_TGT_LO     = 2000,
    parameter int unsigned AUTO_TGT_HI     = 20000
`endif
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             cfg_wr_valid,
    output logic             cfg_wr_ready,
    input  logic [1:0]       cfg_addr,
    input  logic [W_THR-1:0] cfg_wdata,
    input  logic             in_vs,
    input  logic             in_hs,
    input  logic             in_de,
    input  logic             edge_pix,
    output logic [W_THR-1:0] thr_low,
    output logic [W_THR-1:0] thr_high,
    output logic             border_mask,
    output logic [W_CNT-1:0] frame_edge_cnt,
    output logic             frame_done,
    output logic             cfg_err
);

    frame_state_e     state_q, state_d;
    logic             vs_q;
    logic             clr;
    logic             commit;
    logic             wr_fire;
    logic             active;
    logic             unused_hs;

    logic [W_THR-1:0] shd_low_q, shd_high_q;
    logic [W_THR-1:0] act_low_q, act_high_q;
    logic [W_THR-1:0] new_low, new_high;
    logic             new_err;
    logic [W_POS-1:0] shd_rows_q, shd_cols_q;
    logic [W_POS-1:0] act_rows_q, act_cols_q;
    logic [W_CNT-1:0] cnt_q, edge_cnt_q;
    logic             done_q, err_q;

`ifdef CANNY_AUTO_THR_EN
    localparam logic [W_THR-1:0] STEP      = W_THR'(AUTO_STEP);
    localparam logic [W_THR-1:0] THR_MAX   = '1;
    localparam logic [W_THR-1:0] FLOOR_LIM = W_THR'(2 * AUTO_STEP + 1);
    logic host_thr_wr_q;
`endif

    assign unused_hs    = in_hs;
    assign active       = (state_q == StActive);
    assign cfg_wr_ready = (state_q != StCommit);
    assign wr_fire      = cfg_wr_valid && cfg_wr_ready;

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_q <= StIdle;
            vs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            vs_q    <= in_vs;
        end
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_vs && !vs_q) begin
                    state_d = StActive;
                    clr     = 1'b1;
                end
            end
            StActive: begin
                if (!in_vs && vs_q) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = StIdle;
                commit  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Threshold values to apply at commit; an inverted pair is rejected as a whole.
    always_comb begin
        new_low  = act_low_q;
        new_high = act_high_q;
        new_err  = 1'b1;
        if (shd_low_q < shd_high_q) begin
            new_low  = shd_low_q;
            new_high = shd_high_q;
            new_err  = 1'b0;
        end
`ifdef CANNY_AUTO_THR_EN
        if (!host_thr_wr_q) begin
            new_low  = act_low_q;
            new_high = act_high_q;
            new_err  = err_q;
            if (cnt_q > W_CNT'(AUTO_TGT_HI)) begin
                new_high = (act_high_q > THR_MAX - STEP) ? THR_MAX : act_high_q + STEP;
                new_low  = new_high >> 1;
            end else if (cnt_q < W_CNT'(AUTO_TGT_LO)) begin
                new_high = (act_high_q < FLOOR_LIM) ? STEP + W_THR'(1) : act_high_q - STEP;
                new_low  = new_high >> 1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            shd_low_q  <= W_THR'(THR_LOW_RST);
            shd_high_q <= W_THR'(THR_HIGH_RST);
            shd_rows_q <= W_POS'(BORDER_ROWS_RST);
            shd_cols_q <= W_POS'(BORDER_COLS_RST);
            act_low_q  <= W_THR'(THR_LOW_RST);
            act_high_q <= W_THR'(THR_HIGH_RST);
            act_rows_q <= W_POS'(BORDER_ROWS_RST);
            act_cols_q <= W_POS'(BORDER_COLS_RST);
            edge_cnt_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef CANNY_AUTO_THR_EN
            host_thr_wr_q <= 1'b0;
`endif
        end else begin
            done_q <= commit;
            if (wr_fire) begin
                case (cfg_addr)
                    CFG_THR_LOW:     shd_low_q  <= cfg_wdata;
                    CFG_THR_HIGH:    shd_high_q <= cfg_wdata;
                    CFG_BORDER_ROWS: shd_rows_q <= W_POS'(cfg_wdata);
                    CFG_BORDER_COLS: shd_cols_q <= W_POS'(cfg_wdata);
                    default: ;
                endcase
`ifdef CANNY_AUTO_THR_EN
                if ((cfg_addr == CFG_THR_LOW) || (cfg_addr == CFG_THR_HIGH)) begin
                    host_thr_wr_q <= 1'b1;
                end
`endif
            end
            if (commit) begin
                act_low_q  <= new_low;
                act_high_q <= new_high;
                err_q      <= new_err;
                act_rows_q <= shd_rows_q;
                act_cols_q <= shd_cols_q;
                edge_cnt_q <= cnt_q;
`ifdef CANNY_AUTO_THR_EN
                shd_low_q     <= new_low;
                shd_high_q    <= new_high;
                host_thr_wr_q <= 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (active && in_de && edge_pix && !border_mask && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W_CNT'(1);
        end
    end

    canny_pos_cnt #(
        .W_POS (W_POS)
    ) u_pos_cnt (
        .clk         (clk),
        .rst_s       (rst_s),
        .clr         (clr),
        .active      (active),
        .in_de       (in_de),
        .border_rows (act_rows_q),
        .border_cols (act_cols_q),
        .border_mask (border_mask)
    );

    assign thr_low        = act_low_q;
    assign thr_high       = act_high_q;
    assign frame_edge_cnt = edge_cnt_q;
    assign frame_done     = done_q;
    assign cfg_err        = err_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Directed self-checking bench for canny_frame_ctrl (default build, auto-threshold disabled).
module tb_canny_frame_ctrl;

    logic        clk;
    logic        rst_s;
    logic        cfg_wr_valid;
    logic        cfg_wr_ready;
    logic [1:0]  cfg_addr;
    logic [9:0]  cfg_wdata;
    logic        in_vs;
    logic        in_hs;
    logic        in_de;
    logic        edge_pix;
    logic [9:0]  thr_low;
    logic [9:0]  thr_high;
    logic        border_mask;
    logic [19:0] frame_edge_cnt;
    logic        frame_done;
    logic        cfg_err;

    int errors = 0;
    int checks = 0;

    canny_frame_ctrl dut (
        .clk            (clk),
        .rst_s          (rst_s),
        .cfg_wr_valid   (cfg_wr_valid),
        .cfg_wr_ready   (cfg_wr_ready),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .in_vs          (in_vs),
        .in_hs          (in_hs),
        .in_de          (in_de),
        .edge_pix       (edge_pix),
        .thr_low        (thr_low),
        .thr_high       (thr_high),
        .border_mask    (border_mask),
        .frame_edge_cnt (frame_edge_cnt),
        .frame_done     (frame_done),
        .cfg_err        (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [9:0] data);
        cfg_wr_valid = 1'b1;
        cfg_addr     = addr;
        cfg_wdata    = data;
        tick();
        cfg_wr_valid = 1'b0;
    endtask

    // Drives rows x cols de-active lines (one blank cycle after each); optionally checks
    // border_mask per pixel against the expected 1-based row / 0-based column rule.
    task automatic do_lines(input int rows, input int cols, input logic e, input logic chk_mask,
                            input logic act, input int brows, input int bcols);
        for (int r = 1; r <= rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                in_de    = 1'b1;
                in_hs    = 1'b1;
                edge_pix = e;
                #1;
                if (chk_mask) begin
                    chk($sformatf("mask_r%0d_c%0d", r, c), 32'(border_mask),
                        32'(act && (((brows != 0) && (r <= brows)) || (c < bcols))));
                end
                @(posedge clk);
                #1;
            end
            in_de    = 1'b0;
            in_hs    = 1'b0;
            edge_pix = 1'b0;
            tick();
        end
    endtask

    task automatic run_frame(input int rows, input int cols, input logic e, input logic chk_mask,
                             input int brows, input int bcols);
        in_vs = 1'b1;
        tick();
        do_lines(rows, cols, e, chk_mask, 1'b1, brows, bcols);
    endtask

    // vs fall; on return the controller sits in its commit cycle
    task automatic end_frame();
        in_vs = 1'b0;
        tick();
    endtask

    initial begin
        rst_s        = 1'b1;
        cfg_wr_valid = 1'b0;
        cfg_addr     = 2'd0;
        cfg_wdata    = '0;
        in_vs        = 1'b0;
        in_hs        = 1'b0;
        in_de        = 1'b0;
        edge_pix     = 1'b0;
        tick();
        tick();
        chk("rst_thr_low", 32'(thr_low), 32'd50);
        chk("rst_thr_high", 32'(thr_high), 32'd100);
        chk("rst_edge_cnt", 32'(frame_edge_cnt), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_border_mask", 32'(border_mask), 32'd0);
        rst_s = 1'b0;
        tick();
        chk("idle_ready", 32'(cfg_wr_ready), 32'd1);

        // Borders 0/0 only take effect after a commit, so run an empty frame first.
        cfg_write(2'd2, 10'd0);
        cfg_write(2'd3, 10'd0);
        run_frame(0, 0, 1'b0, 1'b0, 0, 0);
        end_frame();
        chk("f0_commit_ready", 32'(cfg_wr_ready), 32'd0);
        tick();
        chk("f0_done", 32'(frame_done), 32'd1);
        chk("f0_cnt", 32'(frame_edge_cnt), 32'd0);
        tick();

        // 4x8 frame, every pixel an edge, no border
        run_frame(4, 8, 1'b1, 1'b1, 0, 0);
        end_frame();
        chk("f1_done_early", 32'(frame_done), 32'd0);
        tick();
        chk("f1_done", 32'(frame_done), 32'd1);
        chk("f1_cnt", 32'(frame_edge_cnt), 32'd32);
        chk("f1_thr_low", 32'(thr_low), 32'd50);
        chk("f1_thr_high", 32'(thr_high), 32'd100);
        tick();
        chk("f1_done_pulse", 32'(frame_done), 32'd0);

        // mid-frame threshold write held until commit
        run_frame(1, 2, 1'b1, 1'b0, 0, 0);
        cfg_write(2'd0, 10'd30);
        cfg_write(2'd1, 10'd90);
        chk("f2_mid_low", 32'(thr_low), 32'd50);
        chk("f2_mid_high", 32'(thr_high), 32'd100);
        do_lines(1, 2, 1'b1, 1'b0, 1'b1, 0, 0);
        chk("f2_pre_low", 32'(thr_low), 32'd50);
        end_frame();
        chk("f2_commit_low", 32'(thr_low), 32'd50);
        tick();
        chk("f2_thr_low", 32'(thr_low), 32'd30);
        chk("f2_thr_high", 32'(thr_high), 32'd90);
        chk("f2_cfg_err", 32'(cfg_err), 32'd0);
        chk("f2_cnt", 32'(frame_edge_cnt), 32'd4);
        tick();

        // inverted pair rejected
        run_frame(1, 1, 1'b1, 1'b0, 0, 0);
        cfg_write(2'd0, 10'd120);
        cfg_write(2'd1, 10'd80);
        end_frame();
        tick();
        chk("f3_thr_low", 32'(thr_low), 32'd30);
        chk("f3_thr_high", 32'(thr_high), 32'd90);
        chk("f3_cfg_err", 32'(cfg_err), 32'd1);
        chk("f3_cnt", 32'(frame_edge_cnt), 32'd1);
        tick();

        // valid pair recovers; borders back to 5/2
        run_frame(1, 1, 1'b1, 1'b0, 0, 0);
        cfg_write(2'd0, 10'd40);
        cfg_write(2'd1, 10'd60);
        cfg_write(2'd2, 10'd5);
        cfg_write(2'd3, 10'd2);
        end_frame();
        tick();
        chk("f4_thr_low", 32'(thr_low), 32'd40);
        chk("f4_thr_high", 32'(thr_high), 32'd60);
        chk("f4_cfg_err", 32'(cfg_err), 32'd0);
        tick();

        // 10x10 frame with border 5/2
        run_frame(10, 10, 1'b1, 1'b1, 5, 2);
        end_frame();
        tick();
        chk("f5_done", 32'(frame_done), 32'd1);
        chk("f5_cnt", 32'(frame_edge_cnt), 32'd40);
        tick();

        // write attempted during the commit cycle waits a cycle
        run_frame(1, 3, 1'b1, 1'b0, 5, 2);
        end_frame();
        cfg_wr_valid = 1'b1;
        cfg_addr     = 2'd0;
        cfg_wdata    = 10'd10;
        #1;
        chk("f6_commit_not_ready", 32'(cfg_wr_ready), 32'd0);
        tick();
        chk("f6_after_ready", 32'(cfg_wr_ready), 32'd1);
        chk("f6_cnt", 32'(frame_edge_cnt), 32'd0);
        chk("f6_low_unchanged", 32'(thr_low), 32'd40);
        tick();
        cfg_wr_valid = 1'b0;
        chk("f6_shadow_only", 32'(thr_low), 32'd40);
        run_frame(0, 0, 1'b0, 1'b0, 0, 0);
        end_frame();
        tick();
        chk("f7_thr_low", 32'(thr_low), 32'd10);
        chk("f7_thr_high", 32'(thr_high), 32'd60);
        tick();

        // reset in mid-frame, released while vs is still high
        run_frame(2, 4, 1'b1, 1'b0, 5, 2);
        rst_s = 1'b1;
        tick();
        tick();
        rst_s = 1'b0;
        chk("f8_rst_thr_low", 32'(thr_low), 32'd50);
        chk("f8_rst_thr_high", 32'(thr_high), 32'd100);
        do_lines(2, 3, 1'b1, 1'b1, 1'b0, 5, 2);
        end_frame();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("f8_no_done_%0d", i), 32'(frame_done), 32'd0);
            tick();
        end
        chk("f8_cnt", 32'(frame_edge_cnt), 32'd0);

        // next full frame counts normally with reset borders 5/2: row 6, cols 2-3
        run_frame(6, 4, 1'b1, 1'b1, 5, 2);
        end_frame();
        tick();
        chk("f9_done", 32'(frame_done), 32'd1);
        chk("f9_cnt", 32'(frame_edge_cnt), 32'd2);
        tick();
        chk("f9_done_pulse", 32'(frame_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/canny_frame_ctrl.md
Name: canny_frame_ctrl

Overview:
Frame-level controller for the Canny edge pipeline. Accepts host writes to double-threshold and border-suppression settings into shadow registers, and commits them atomically at frame end so thresholds never change mid-frame. Tracks row/column position to drive the border-suppression mask. Counts surviving edge pixels per frame. Sits beside the Canny datapath, driven by its output timing (vs/hs/de, edge bit).

Parameters:
W_THR, 10, threshold / gradient-magnitude width
W_CNT, 20, per-frame edge-count width
W_POS, 11, row/column counter width
THR_LOW_RST, 50, low threshold after reset
THR_HIGH_RST, 100, high threshold after reset
BORDER_ROWS_RST, 5, rows suppressed at frame top after reset
BORDER_COLS_RST, 2, columns suppressed at line start after reset
AUTO_STEP, 4, auto-threshold step (optional feature only)
AUTO_TGT_LO, 2000, edge count below which the high threshold is lowered
AUTO_TGT_HI, 20000, edge count above which the high threshold is raised

Ports:
clk  in  1  pixel clock
rst_s  in  1  asynchronous reset, active-high
cfg_wr_valid  in  1  host write request
cfg_wr_ready  out  1  write accepted when valid & ready
cfg_addr  in  2  0=thr_low, 1=thr_high, 2=border_rows, 3=border_cols
cfg_wdata  in  W_THR  write data (addr 2/3 use low W_POS bits, zero-extended)
in_vs  in  1  frame valid, active-high
in_hs  in  1  line sync (pass-through timing reference only)
in_de  in  1  pixel valid
edge_pix  in  1  edge decision for the current de pixel
thr_low  out  W_THR  active low threshold
thr_high  out  W_THR  active high threshold
border_mask  out  1  1 = current pixel is in the suppressed border
frame_edge_cnt  out  W_CNT  edge count of the last completed frame
frame_done  out  1  one-cycle pulse on commit
cfg_err  out  1  sticky: last commit rejected

Behaviour:
- Reset values: thr_low=THR_LOW_RST, thr_high=THR_HIGH_RST, shadows equal the active values, frame_edge_cnt=0, frame_done=0, cfg_err=0, border_mask=0, FSM=IDLE, vs_q=1 (prevents a false rising edge after reset), row/col=0.
- FSM states: IDLE, ACTIVE, COMMIT.
  - IDLE -> ACTIVE on vs rise (in_vs=1, vs_q=0). On that edge, clear row, col and the running count.
  - ACTIVE -> COMMIT on vs fall (in_vs=0, vs_q=1).
  - COMMIT -> IDLE unconditionally after 1 cycle.
  - A vs fall seen in IDLE is ignored. A frame already in progress when reset deasserts is not counted; the FSM waits for the next vs rise.
- Commit (the edge leaving COMMIT):
  - If shadow_low < shadow_high: copy all shadows to active, clear cfg_err.
  - Otherwise keep the previous thresholds, set cfg_err=1. Border shadows still commit.
  - Same edge: frame_edge_cnt <= running count; frame_done=1 for exactly that one cycle.
- cfg_wr_ready=1 in all states except COMMIT. An accepted write updates only its shadow register on the same edge. Multiple writes to one address within a frame: last write wins.
- Row counter: increments on the rising edge of in_de while ACTIVE (first line = row 1). Column counter: 0 at in_de rise, +1 per in_de cycle. Both saturate at all-ones.
- border_mask (combinational from registered counters) = ACTIVE & in_de & (row <= border_rows | col < border_cols). border_rows=0 or border_cols=0 disables that axis.
- Running count: +1 per cycle with ACTIVE & in_de & edge_pix & ~border_mask. Saturates at 2^W_CNT-1.
- Active thresholds are constant from vs rise to vs fall; they never change inside a frame.

Optional Feature:
CANNY_AUTO_THR_EN.
- Defined: at commit, if no host write to addr 0/1 occurred during the frame:
  - count > AUTO_TGT_HI: thr_high += AUTO_STEP, saturating at 2^W_THR-1.
  - count < AUTO_TGT_LO: thr_high -= AUTO_STEP, floor AUTO_STEP+1.
  - thr_low is set to thr_high>>1 in either case.
  - Host writes in the frame take priority over auto adjustment.
- Undefined: thresholds change only via host writes; no adjust logic is synthesized.

Decomposition:
- Shared package canny_pkg holds:
  - FSM state enum (IDLE/ACTIVE/COMMIT)
  - cfg address constants (CFG_THR_LOW=0, CFG_THR_HIGH=1, CFG_BORDER_ROWS=2, CFG_BORDER_COLS=3)
  - W_THR / W_CNT defaults
- One sub-module, canny_pos_cnt: row/column counters plus border_mask.

Test Plan:
- Reset, then a 4x8 frame with edge_pix=1, border 0/0 (written before the frame) -> frame_done one cycle after vs fall; frame_edge_cnt=32; thr_low=50, thr_high=100.
- Write thr_low=30, thr_high=90 mid-frame -> thr outputs stay 50/100 until commit, then 30/90; cfg_err=0.
- Write thr_low=120, thr_high=80 -> at commit thresholds unchanged, cfg_err=1; next valid pair 40/60 -> applied, cfg_err=0.
- Defaults 5/2, 10x10 frame with all edges -> mask on rows 1-5 and cols 0-1; frame_edge_cnt=5*8=40.
- Write attempted during COMMIT -> cfg_wr_ready=0 that cycle; write held by the host completes the next cycle.
- Reset asserted mid-frame, released while vs=1 -> no frame_done at that vs fall; next full frame counts normally.
